module_fetch: RTL and testbench
===============================

MODULE_FETCH -- requirements
Module: module_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; SHALL have bits [1:0] = 2'b00.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; one clock; synchronous, active-high.
REQ-004 imem_req_o  output  1  instruction-memory request valid.
REQ-005 imem_addr_o  output  32  request address; equals current PC.
REQ-006 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-007 imem_rvalid_i  input  1  read data valid for the oldest granted request.
REQ-008 imem_rdata_i  input  32  instruction word.
REQ-009 redirect_i  input  1  one-cycle pulse from branch/jump resolution.
REQ-010 redirect_pc_i  input  32  new PC; sampled when redirect_i=1.
REQ-011 instr_valid_o  output  1  instr_o/pc_o hold a fetched instruction.
REQ-012 instr_ready_i  input  1  decode/extend stage consumes the instruction.
REQ-013 instr_o  output  32  registered instruction word; bits [31:7] feed the immediate extender.
REQ-014 pc_o  output  32  address of instr_o.
REQ-015 pc_plus4_o  output  32  pc_o + 4, modulo 2^32.
REQ-016 misaligned_o  output  1  sticky redirect-misalignment flag.

Function
REQ-017 The FSM SHALL have the states S_REQ, S_WAIT, S_HOLD, S_FLUSH and S_TRAP.
REQ-018 In S_REQ: imem_req_o=1; when imem_gnt_i=1, go to S_WAIT.
REQ-019 In S_WAIT: imem_req_o=0; when imem_rvalid_i=1, register imem_rdata_i into instr_o and PC into pc_o, then go to S_HOLD.
REQ-020 In S_HOLD: instr_valid_o=1; when instr_ready_i=1, PC := PC+4 (0xFFFF_FFFC wraps to 0x0000_0000), then go to S_REQ.
REQ-021 Minimum latency: request granted in cycle N, rvalid in N+1, instr_valid_o=1 in N+2; peak throughput is one instruction per 3 cycles.
REQ-022 instr_o and pc_o SHALL stay stable while instr_valid_o=1 and instr_ready_i=0.
REQ-023 Redirect with redirect_pc_i[1:0]=00 from any state except S_TRAP: PC := redirect_pc_i; instr_valid_o drops next cycle.
REQ-024 Redirect target state:
- from S_REQ or S_HOLD -> S_REQ;
- from S_REQ with simultaneous gnt -> S_FLUSH;
- from S_WAIT without rvalid -> S_FLUSH;
- from S_WAIT with rvalid -> S_REQ, data discarded.
REQ-025 In S_FLUSH: imem_req_o=0; the next imem_rvalid_i is discarded; then go to S_REQ.
REQ-026 Redirect and handshake (S_HOLD, instr_ready_i=1) in the same cycle: the instruction counts as consumed and redirect_pc_i takes priority over PC+4.
REQ-027 Redirect with redirect_pc_i[1:0]!=00: misaligned_o := 1 and go to S_TRAP; in S_TRAP imem_req_o=0 and instr_valid_o=0 until reset.
REQ-028 A second redirect while in S_FLUSH SHALL update PC and remain in S_FLUSH.
REQ-029 imem_rvalid_i in S_REQ or S_HOLD (no request outstanding) SHALL be ignored.

Reset
REQ-030 rst_i=1 at a clock edge sets state=S_REQ, PC=RESET_PC, instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=RESET_PC, misaligned_o=0.
REQ-031 rst_i overrides redirect_i and all handshakes in the same cycle.
REQ-032 Reset mid-transaction SHALL abandon any outstanding response without entering S_FLUSH; the memory is reset by the same rst_i.
REQ-033 imem_req_o=1 in the first cycle after reset deasserts.

Structure
REQ-034 A shared package pkg_fetch SHALL hold the fetch_state_t enum, NOP_INSTR=32'h0000_0013 and PC_INC=32'd4.
REQ-035 The PC register with its next-PC mux (PC+4, redirect, hold) SHALL be one sub-module, module_pc_reg; the FSM and the instruction register stay in module_fetch.

Verification
REQ-036 Reset release, gnt=1 in the first cycle, rvalid next cycle with 0x00500093, ready=1 -> instr_valid_o in the 3rd cycle; instr_o=0x00500093, pc_o=0, next imem_addr_o=4.
REQ-037 ready held low for 5 cycles in S_HOLD -> instr_o/pc_o unchanged; one PC increment after ready rises.
REQ-038 Redirect to 0x100 while in S_WAIT, then rvalid with 0xDEADBEEF -> word discarded; next request address is 0x100.
REQ-039 PC=0xFFFF_FFFC, handshake -> pc_plus4_o was 0; next imem_addr_o=0.
REQ-040 Redirect to 0x102 -> misaligned_o=1, imem_req_o stays 0; rst_i clears both and fetching resumes at RESET_PC.
REQ-041 Redirect to 0x200 together with a handshake in S_HOLD -> next request address is 0x200, not pc+4.

Source files
------------

// File: rtl/pkg_fetch.sv
// Shared definitions for the instruction fetch unit: FSM states and fixed constants.
package pkg_fetch;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FLUSH,
    S_TRAP
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Instruction addresses must be word aligned; anything else is a trap condition.
  function automatic logic isWordAligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/module_pc_reg.sv
// Program counter register with its next-PC selection: redirect, sequential step or hold.
module module_pc_reg
  import pkg_fetch::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_loadPc,
  input  logic        i_inc,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  // A redirect wins over the sequential step; the +4 wraps naturally at 2^32.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_loadPc;
    end else if (i_inc) begin
      r_pc <= r_pc + PC_INC;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/module_fetch.sv
// Instruction fetch unit: issues one memory request at a time, holds the returned
// word for decode, and handles redirects, in-flight response flushing and
// misaligned-redirect trapping.
module module_fetch
  import pkg_fetch::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misaligned_o
);

  fetch_state_t r_state;
  fetch_state_t w_nextState;

  logic        r_req;
  logic        r_valid;
  logic        r_misaligned;
  logic [31:0] r_instr;
  logic [31:0] r_pcOut;

  logic [31:0] w_pc;
  logic        w_redirAligned;
  logic        w_redirMisaligned;
  logic        w_consume;
  logic        w_capture;

  // Once trapped, redirects are ignored until reset.
  assign w_redirAligned    = redirect_i && (r_state != S_TRAP) &&  isWordAligned(redirect_pc_i);
  assign w_redirMisaligned = redirect_i && (r_state != S_TRAP) && !isWordAligned(redirect_pc_i);

  // A handshake only advances the PC sequentially when no redirect overrides it.
  assign w_consume = (r_state == S_HOLD) && instr_ready_i && !redirect_i;

  // Response data is kept only when no redirect arrives in the same cycle.
  assign w_capture = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;

  module_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pcReg (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_load   (w_redirAligned),
    .i_loadPc (redirect_pc_i),
    .i_inc    (w_consume),
    .o_pc     (w_pc)
  );

  // Next-state selection. A redirect in S_FLUSH coinciding with the stale
  // response returns to S_REQ, since nothing is left in flight to wait for.
  always_comb begin
    w_nextState = r_state;
    if (w_redirMisaligned) begin
      w_nextState = S_TRAP;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_redirAligned) begin
            w_nextState = imem_gnt_i ? S_FLUSH : S_REQ;
          end else if (imem_gnt_i) begin
            w_nextState = S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redirAligned) begin
            w_nextState = imem_rvalid_i ? S_REQ : S_FLUSH;
          end else if (imem_rvalid_i) begin
            w_nextState = S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_redirAligned || instr_ready_i) begin
            w_nextState = S_REQ;
          end
        end
        S_FLUSH: begin
          if (imem_rvalid_i) begin
            w_nextState = S_REQ;
          end
        end
        S_TRAP: begin
          w_nextState = S_TRAP;
        end
        default: begin
          w_nextState = S_REQ;
        end
      endcase
    end
  end

  // State, registered handshake outputs, instruction register and sticky trap flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_REQ;
      r_req        <= 1'b1;
      r_valid      <= 1'b0;
      r_misaligned <= 1'b0;
      r_instr      <= NOP_INSTR;
      r_pcOut      <= RESET_PC;
    end else begin
      r_state <= w_nextState;
      r_req   <= (w_nextState == S_REQ);
      r_valid <= (w_nextState == S_HOLD);
      if (w_redirMisaligned) begin
        r_misaligned <= 1'b1;
      end
      if (w_capture) begin
        r_instr <= imem_rdata_i;
        r_pcOut <= w_pc;
      end
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = w_pc;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign pc_o          = r_pcOut;
  assign pc_plus4_o    = r_pcOut + PC_INC;
  assign misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_module_fetch.sv
// Self-checking bench for module_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the fetch stream.
module tb_module_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        misaligned_o;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model of the fetch stream
  logic [31:0] mPc = RESET_PC;
  logic [31:0] mPcOut = RESET_PC;
  logic [31:0] mInstr = NOP;
  bit          mValid = 0;
  bit          mWaiting = 0;
  int          mDiscard = 0;
  bit          mTrap = 0;
  bit          mMis = 0;

  // Outstanding granted addresses of the behavioural memory
  logic [31:0] memQ[$];

  module_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .misaligned_o  (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // The unit asks for a new word only when idle, unblocked and not trapped.
  function automatic bit modelReq();
    return !mTrap && !mValid && !mWaiting && (mDiscard == 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("imem_req", {31'd0, imem_req_o}, {31'd0, modelReq()});
    checkOutput("instr_valid", {31'd0, instr_valid_o}, {31'd0, mValid});
    checkOutput("misaligned", {31'd0, misaligned_o}, {31'd0, mMis});
    checkOutput("pc_plus4", pc_plus4_o, mPcOut + 32'd4);
    if (modelReq()) checkOutput("imem_addr", imem_addr_o, mPc);
    if (mValid) begin
      checkOutput("instr", instr_o, mInstr);
      checkOutput("pc", pc_o, mPcOut);
    end
  endtask

  task automatic applyStimulus(input logic iRst, input logic iGnt, input logic iRv,
                               input logic [31:0] iRdata, input logic iRedir,
                               input logic [31:0] iRpc, input logic iReady);
    logic        sReq;
    logic [31:0] sAddr;
    bit          req;
    bit          take;
    bit          drop;
    rst_i = iRst; imem_gnt_i = iGnt; imem_rvalid_i = iRv; imem_rdata_i = iRdata;
    redirect_i = iRedir; redirect_pc_i = iRpc; instr_ready_i = iReady;
    sReq = imem_req_o; sAddr = imem_addr_o;
    req  = modelReq();
    take = iRv && mWaiting && (mDiscard == 0);
    drop = iRv && (mDiscard > 0);
    @(posedge clk_i);
    if (iRst) begin
      memQ.delete();
    end else begin
      if (iRv && memQ.size() > 0) void'(memQ.pop_front());
      if (sReq === 1'b1 && iGnt) memQ.push_back(sAddr);
    end
    if (iRst) begin
      mPc = RESET_PC; mPcOut = RESET_PC; mInstr = NOP;
      mValid = 0; mWaiting = 0; mDiscard = 0; mTrap = 0; mMis = 0;
    end else if (!mTrap) begin
      if (iRedir) begin
        if (iRpc[1:0] != 2'b00) begin
          mTrap = 1; mMis = 1; mValid = 0; mWaiting = 0; mDiscard = 0;
        end else begin
          mPc = iRpc; mValid = 0;
          if (req && iGnt) mDiscard = 1;
          else if (mWaiting) begin mWaiting = 0; mDiscard = iRv ? 0 : 1; end
          else if (drop) mDiscard = 0;
        end
      end else if (req && iGnt) begin
        mWaiting = 1;
      end else if (take) begin
        mInstr = iRdata; mPcOut = mPc; mValid = 1; mWaiting = 0;
      end else if (drop) begin
        mDiscard = 0;
      end else if (mValid && iReady) begin
        mPc = mPc + 32'd4; mValid = 0;
      end
    end
    @(negedge clk_i);
    checkAgainstModel();
  endtask

  // One cycle of randomised traffic with a well-behaved in-order memory.
  task automatic randomCycle();
    logic        rst, gnt, rv, redir, ready;
    logic [31:0] rdata, rpc, r;
    rst   = mTrap ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
    gnt   = ($urandom_range(0, 9) < 6);
    if (memQ.size() > 0) begin
      rv = ($urandom_range(0, 2) != 0); rdata = memWord(memQ[0]);
    end else begin
      rv = ($urandom_range(0, 9) == 0); rdata = $urandom;
    end
    redir = ($urandom_range(0, 11) == 0);
    r = $urandom;
    case ($urandom_range(0, 39))
      0:       rpc = {r[31:2], 2'b10};
      1, 2:    rpc = 32'hFFFF_FFFC;
      default: rpc = {r[31:2], 2'b00};
    endcase
    ready = ($urandom_range(0, 2) != 0);
    applyStimulus(rst, gnt, rv, rdata, redir, rpc, ready);
  endtask

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 32'hFFFF_FFFF, 1, 32'h40, 1);
    checkOutput("rst_instr", instr_o, NOP);
    checkOutput("rst_req", {31'd0, imem_req_o}, 32'd1);

    // First fetch with minimum latency
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h0050_0093, 0, 0, 0);
    checkOutput("lat_valid", {31'd0, instr_valid_o}, 32'd1);
    checkOutput("lat_instr", instr_o, 32'h0050_0093);
    checkOutput("lat_pc", pc_o, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("lat_next_addr", imem_addr_o, 32'h4);

    // Back-pressure in hold
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h00A0_0113, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_instr", instr_o, 32'h00A0_0113);
    checkOutput("stall_pc", pc_o, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("stall_next_addr", imem_addr_o, 32'h8);

    // Redirect while waiting: the in-flight word is flushed
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 0);
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("flush_valid", {31'd0, instr_valid_o}, 32'd0);
    checkOutput("flush_addr", imem_addr_o, 32'h100);

    // Redirect coinciding with a handshake
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h1111_1111, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 1);
    checkOutput("redir_hs_addr", imem_addr_o, 32'h200);

    // PC wrap-around
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h2222_2222, 0, 0, 0);
    checkOutput("wrap_plus4", pc_plus4_o, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("wrap_addr", imem_addr_o, 32'h0);

    // Misaligned redirect traps until reset
    applyStimulus(0, 0, 0, 0, 1, 32'h102, 0);
    checkOutput("trap_mis", {31'd0, misaligned_o}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 32'h3333_3333, 1, 32'h300, 1);
    checkOutput("trap_req", {31'd0, imem_req_o}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("trap_rst_mis", {31'd0, misaligned_o}, 32'd0);
    checkOutput("trap_rst_addr", imem_addr_o, RESET_PC);

    // Random traffic
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) randomCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
